// File: rtl/robot_motor_driver.sv
// rtl/robot_motor_driver.sv - half-bridge motor gate driver with soft-start PWM and dead-time interlock
module robot_motor_driver #(
    parameter int PWM_BITS    = 8,
    parameter int DEAD_CYCLES = 4,
    parameter int RAMP_DIV    = 16,
    parameter int RAMP_STEP   = 8,
    parameter int MAX_DUTY    = 255
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                Z1,
    input  logic                Z2,
    output logic                hs_gate,
    output logic                ls_gate,
    output logic [PWM_BITS-1:0] duty,
    output logic [1:0]          mode,
    output logic                dead_active
);

    localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    localparam logic [DW-1:0]       DEAD_LOAD = DW'(DEAD_CYCLES - 1);
    localparam logic [RW-1:0]       RAMP_LAST = RW'(RAMP_DIV - 1);
    localparam logic [PWM_BITS:0]   STEP_W    = (PWM_BITS + 1)'(RAMP_STEP);
    localparam logic [PWM_BITS:0]   MAX_W     = (PWM_BITS + 1)'(MAX_DUTY);
    localparam logic [PWM_BITS-1:0] MAX_D     = PWM_BITS'(MAX_DUTY);

    typedef enum logic [1:0] {
        ST_COAST = 2'b00,
        ST_DEAD  = 2'b01,
        ST_DRIVE = 2'b10,
        ST_BRAKE = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        CMD_COAST = 2'b00,
        CMD_DRIVE = 2'b01,
        CMD_BRAKE = 2'b10
    } cmd_t;

    state_t              r_state;
    state_t              w_state_nxt;
    cmd_t                w_cmd;
    logic [DW-1:0]       r_dead_cnt;
    logic [DW-1:0]       w_dead_cnt_nxt;
    logic [RW-1:0]       r_ramp_cnt;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [PWM_BITS-1:0] r_duty;
    logic [PWM_BITS:0]   w_duty_sum;
    logic [PWM_BITS-1:0] w_duty_sat;
    logic                r_hs_gate;
    logic                r_ls_gate;

    // Brake wins when both commands are asserted.
    always_comb begin
        w_cmd = CMD_COAST;
        if (Z2) begin
            w_cmd = CMD_BRAKE;
        end else if (Z1) begin
            w_cmd = CMD_DRIVE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= ST_COAST;
            r_dead_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_dead_cnt <= w_dead_cnt_nxt;
        end
    end

    // Any switch between drive and brake passes through DEAD; coasting is always immediate.
    always_comb begin
        w_state_nxt    = r_state;
        w_dead_cnt_nxt = r_dead_cnt;
        case (r_state)
            ST_COAST: begin
                if (w_cmd != CMD_COAST) begin
                    w_state_nxt    = ST_DEAD;
                    w_dead_cnt_nxt = DEAD_LOAD;
                end
            end
            ST_DRIVE: begin
                if (w_cmd == CMD_BRAKE) begin
                    w_state_nxt    = ST_DEAD;
                    w_dead_cnt_nxt = DEAD_LOAD;
                end else if (w_cmd == CMD_COAST) begin
                    w_state_nxt = ST_COAST;
                end
            end
            ST_BRAKE: begin
                if (w_cmd == CMD_DRIVE) begin
                    w_state_nxt    = ST_DEAD;
                    w_dead_cnt_nxt = DEAD_LOAD;
                end else if (w_cmd == CMD_COAST) begin
                    w_state_nxt = ST_COAST;
                end
            end
            ST_DEAD: begin
                if (r_dead_cnt != '0) begin
                    w_dead_cnt_nxt = r_dead_cnt - 1'b1;
                end else begin
                    case (w_cmd)
                        CMD_DRIVE: w_state_nxt = ST_DRIVE;
                        CMD_BRAKE: w_state_nxt = ST_BRAKE;
                        default:   w_state_nxt = ST_COAST;
                    endcase
                end
            end
            default: w_state_nxt = ST_COAST;
        endcase
    end

    assign w_duty_sum = {1'b0, r_duty} + STEP_W;
    assign w_duty_sat = (w_duty_sum > MAX_W) ? MAX_D : w_duty_sum[PWM_BITS-1:0];

    // Outside DRIVE the ramp is held cleared so every entry restarts from zero duty.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pwm_cnt  <= '0;
            r_ramp_cnt <= '0;
            r_duty     <= '0;
            r_hs_gate  <= 1'b0;
            r_ls_gate  <= 1'b0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
            if (r_state == ST_DRIVE) begin
                if (r_ramp_cnt == RAMP_LAST) begin
                    r_ramp_cnt <= '0;
                    r_duty     <= w_duty_sat;
                end else begin
                    r_ramp_cnt <= r_ramp_cnt + 1'b1;
                end
            end else begin
                r_ramp_cnt <= '0;
                r_duty     <= '0;
            end
            r_hs_gate <= (r_state == ST_DRIVE) && (r_pwm_cnt < r_duty);
            r_ls_gate <= (r_state == ST_BRAKE);
        end
    end

    assign hs_gate     = r_hs_gate;
    assign ls_gate     = r_ls_gate;
    assign duty        = r_duty;
    assign mode        = r_state;
    assign dead_active = (r_state == ST_DEAD);

endmodule

// File: tb/tb_robot_motor_driver.sv
// tb/tb_robot_motor_driver.sv - directed self-checking bench for robot_motor_driver
module tb_robot_motor_driver;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       Z1 = 1'b0;
    logic       Z2 = 1'b0;
    logic       hs_gate;
    logic       ls_gate;
    logic [7:0] duty;
    logic [1:0] mode;
    logic       dead_active;

    int n_checks = 0;
    int n_pass   = 0;

    int cyc      = 0;
    int last_hs  = -1000;
    int last_ls  = -1000;
    int min_gap  = 1000;
    int overlaps = 0;
    logic prev_hs = 1'b0;
    logic prev_ls = 1'b0;

    robot_motor_driver dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .Z1          (Z1),
        .Z2          (Z2),
        .hs_gate     (hs_gate),
        .ls_gate     (ls_gate),
        .duty        (duty),
        .mode        (mode),
        .dead_active (dead_active)
    );

    always #5 clk = ~clk;

    // Gate monitor: overlap count and minimum both-off gap between opposite gates.
    always @(negedge clk) begin
        cyc++;
        if (hs_gate && ls_gate) overlaps++;
        if (ls_gate && !prev_ls && (cyc - last_hs - 1) < min_gap) min_gap = cyc - last_hs - 1;
        if (hs_gate && !prev_hs && (cyc - last_ls - 1) < min_gap) min_gap = cyc - last_ls - 1;
        if (hs_gate) last_hs = cyc;
        if (ls_gate) last_ls = cyc;
        prev_hs = hs_gate;
        prev_ls = ls_gate;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int hs_cnt;
    int exp_duty;

    initial begin
        // Reset held with drive requested
        Z1 = 1'b1; Z2 = 1'b0; reset_n = 1'b0;
        step(3);
        check("rst_hs", hs_gate, 0);
        check("rst_ls", ls_gate, 0);
        check("rst_duty", duty, 0);
        check("rst_mode", mode, 0);
        check("rst_dead", dead_active, 0);

        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("rel_mode_dead", mode, 1);
            check("rel_dead_act", dead_active, 1);
        end
        step(1);
        check("rel_mode_drive", mode, 2);
        check("rel_duty0", duty, 0);

        // Soft-start ramp
        hs_cnt = 0;
        for (int k = 1; k <= 600; k++) begin
            step(1);
            if (k <= 16 && hs_gate) hs_cnt++;
            if ((k % 16) == 0 || (k % 16) == 15) begin
                exp_duty = 8 * (k / 16);
                if (exp_duty > 255) exp_duty = 255;
                check($sformatf("ramp_k%0d", k), duty, exp_duty);
            end
        end
        check("hs_cnt_duty0", hs_cnt, 0);
        hs_cnt = 0;
        for (int k = 0; k < 256; k++) begin
            step(1);
            if (hs_gate) hs_cnt++;
        end
        check("hs_cnt_duty255", hs_cnt, 255);
        check("duty_sat", duty, 255);

        // Drive to brake
        Z2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("d2b_mode_dead", mode, 1);
            check("d2b_ls_off", ls_gate, 0);
            if (i > 0) check("d2b_duty0", duty, 0);
        end
        step(1);
        check("d2b_mode_brake", mode, 3);
        check("d2b_ls_still_off", ls_gate, 0);
        step(1);
        check("d2b_ls_on", ls_gate, 1);
        check("d2b_hs_off", hs_gate, 0);

        // Brake to coast, no dead phase
        Z1 = 1'b0; Z2 = 1'b0;
        step(1);
        check("b2c_mode", mode, 0);
        check("b2c_dead", dead_active, 0);
        step(1);
        check("b2c_ls_off", ls_gate, 0);

        // Coast with both commands is brake
        Z1 = 1'b1; Z2 = 1'b1;
        step(1);
        check("both_mode_dead", mode, 1);
        step(3);
        check("both_mode_dead_end", mode, 1);
        step(1);
        check("both_mode_brake", mode, 3);
        step(1);
        check("both_ls_on", ls_gate, 1);

        // Brake to drive, ramp a little
        Z1 = 1'b1; Z2 = 1'b0;
        step(5);
        check("b2d_mode", mode, 2);
        check("b2d_duty0", duty, 0);
        step(40);
        check("b2d_duty16", duty, 16);

        // Command change during DEAD does not restart it
        Z2 = 1'b1;
        step(1);
        check("cd_mode_dead0", mode, 1);
        step(1);
        check("cd_mode_dead1", mode, 1);
        Z2 = 1'b0;
        step(1);
        check("cd_mode_dead2", mode, 1);
        step(1);
        check("cd_mode_dead3", mode, 1);
        step(1);
        check("cd_mode_drive", mode, 2);
        check("cd_duty0", duty, 0);
        step(16);
        check("cd_duty8", duty, 8);

        // Mid-operation reset while braking
        Z2 = 1'b1;
        step(6);
        check("mr_pre_mode", mode, 3);
        check("mr_pre_ls", ls_gate, 1);
        reset_n = 1'b0;
        step(1);
        check("mr_ls", ls_gate, 0);
        check("mr_mode", mode, 0);
        check("mr_duty", duty, 0);
        reset_n = 1'b1; Z1 = 1'b0; Z2 = 1'b0;
        step(2);
        check("mr_coast", mode, 0);

        check("no_overlap", overlaps, 0);
        check("dead_gap_ok", (min_gap >= 4) ? 1 : 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
